mul_fu_pipe: RTL and testbench
==============================

Name: mul_fu_pipe

Overview:
- Pipelined RV32M multiply functional unit that sits directly downstream of a res_station instance.
- Accepts one ready-to-execute op per cycle (operands already read), computes over STAGES cycles, then requests the CDB and broadcasts pd/rob/value when granted.
- Tracks each in-flight op's speculative branch mask so early flushes kill wrong-path ops and branch resolves clear mask bits.

Parameters:
STAGES, 3, pipeline depth from issue acceptance to result register (>=2)
P_REG_NUM, 64, physical register count; pd width = $clog2(P_REG_NUM)
ROB_DEPTH, 16, ROB entries; rob tag width = $clog2(ROB_DEPTH)+1
EBR_NUM, 4, early-branch-recovery slots; width of branch mask

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
issue_valid  in  1  res station presents an op (res_station out_valid)
issue_ready  out  1  unit accepts this cycle (drives res_station ready)
issue_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
issue_rs1_v  in  32  operand 1
issue_rs2_v  in  32  operand 2
issue_pd  in  $clog2(P_REG_NUM)  destination physical reg
issue_rob  in  $clog2(ROB_DEPTH)+1  ROB tag
issue_br_mask  in  EBR_NUM  outstanding branch dependencies
early_flush  in  1  mispredict recovery this cycle
flush_idx  in  $clog2(EBR_NUM)  slot being flushed
resolve  in  1  branch in slot resolve_idx resolved correct
resolve_idx  in  $clog2(EBR_NUM)  slot resolved
cdb_req  out  1  result valid, requesting CDB
cdb_grant  in  1  arbiter grant (combinational from cdb_req allowed)
cdb_pd  out  $clog2(P_REG_NUM)  broadcast pd
cdb_rob  out  $clog2(ROB_DEPTH)+1  broadcast ROB tag
cdb_value  out  32  result
busy  out  1  any stage valid

Behaviour:
- Stage s holds {valid, funct3, operands/partial product, pd, rob, br_mask}. Stage STAGES-1 is the result register feeding cdb_*.
- Reset: all stage valid bits 0; cdb_req=0, busy=0, cdb_pd/rob/value=0. issue_ready=1 in the first cycle after reset.
- Advance rule: last stage frees when !valid or (cdb_req && cdb_grant). Stage s advances when stage s+1 is empty or advancing (bubble collapse). Stage 0 accepts when empty or advancing.
- issue_ready = stage0_can_accept && !early_flush. Handshake issue_valid && issue_ready captures the op at the clock edge. issue_ready must not depend on issue_valid.
- Latency: an op accepted at edge T with no stalls asserts cdb_req from edge T+STAGES-1 onward. Throughput is 1 op/cycle with continuous grant.
- Arithmetic: extend operands to 33 bits (sign-extend rs1 for MULH/MULHSU, rs2 for MULH only, otherwise zero-extend) and form a 66-bit signed product. MUL returns bits[31:0]; others return bits[63:32]. funct3 values above 011 return 0 (never issued).
- Stall hold: while cdb_req && !cdb_grant, cdb_* outputs stay stable and upstream stages fill bubbles, then hold.
- early_flush: same cycle, every stage with br_mask[flush_idx]=1 has valid cleared at the edge, including the result stage. The incoming op is not accepted (issue_ready=0). cdb_req stays combinationally valid-based; the arbiter ignores the flush cycle (grant during a flush of the result stage has no effect).
- resolve (and !early_flush): clear br_mask[resolve_idx] in every stage at the edge. An op accepted that cycle also has that bit cleared. If both are asserted, early_flush wins and resolve is ignored.
- The flush mask check uses each stage's mask before that cycle's resolve clear.
- busy = OR of stage valid bits.

Decomposition:
- CDB_types package holds P_REG_NUM, ROB_DEPTH, EBR_NUM, CDB_NUM, and a new mul_stage_t struct {valid, funct3, pd, rob, br_mask}, plus funct3 localparams MUL_OP/MULH_OP/MULHSU_OP/MULHU_OP.
- One sub-module, mul_core: a pure datapath 33x33 signed multiplier split across STAGES registers with an enable per stage, driven by the advance signals.

Test Plan:
- Reset, then issue MUL 7*6 pd=5 rob=3 with grant held 1 -> cdb_req at cycle 2 after acceptance, value 42, pd 5, rob 3. Next cycle cdb_req=0.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF. MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001.
- Back-to-back 4 ops with cdb_grant=0 for 5 cycles -> issue_ready drops after STAGES ops, cdb_* stable. On grant, results emerge in issue order, one per cycle.
- Ops with masks 0001, 0010, 0000 in flight, early_flush flush_idx=0 -> only the 0001 op vanishes. The other two broadcast, and issue_ready=0 that cycle.
- Op with mask 0100, resolve resolve_idx=2, then early_flush flush_idx=2 -> op survives and broadcasts. Simultaneous resolve+flush on the same slot -> op killed.
- rst asserted mid-stall with 3 valid stages -> next cycle busy=0, cdb_req=0, issue_ready=1.

Source files
------------

// File: rtl/CDB_types.sv
// Shared CDB/back-end types: machine sizes, multiply opcodes and the
// per-stage bookkeeping record of the multiply unit.
package CDB_types;

    localparam int P_REG_NUM = 64;
    localparam int ROB_DEPTH = 16;
    localparam int EBR_NUM   = 4;
    localparam int CDB_NUM   = 4;

    localparam int PD_W      = $clog2(P_REG_NUM);
    localparam int ROB_W     = $clog2(ROB_DEPTH) + 1;
    localparam int EBR_IDX_W = $clog2(EBR_NUM);

    localparam logic [2:0] MUL_OP    = 3'b000;
    localparam logic [2:0] MULH_OP   = 3'b001;
    localparam logic [2:0] MULHSU_OP = 3'b010;
    localparam logic [2:0] MULHU_OP  = 3'b011;

    // Control/tag half of one multiply pipeline stage (data lives in mul_core).
    typedef struct packed {
        logic                 valid;
        logic [2:0]           funct3;
        logic [PD_W-1:0]      pd;
        logic [ROB_W-1:0]     rob;
        logic [EBR_NUM-1:0]   br_mask;
    } mul_stage_t;

    // Branch bookkeeping applied to a stage value as it is written:
    // a flush of a slot the op depends on kills it; otherwise a resolve
    // drops that dependency. Flush takes priority over resolve.
    function automatic mul_stage_t apply_branch(
        input mul_stage_t           s,
        input logic                 flush,
        input logic [EBR_IDX_W-1:0] flush_idx,
        input logic                 resolve,
        input logic [EBR_IDX_W-1:0] resolve_idx
    );
        mul_stage_t r;
        r = s;
        if (flush) begin
            if (s.br_mask[flush_idx]) r.valid = 1'b0;
        end else if (resolve) begin
            r.br_mask[resolve_idx] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_core.sv
// Datapath of the multiply unit: operand register (stage 0), 33x33 signed
// product and result select (stage 1), then plain result pipeline registers
// up to the result register. Each stage loads only when its enable is high,
// so data stays aligned with the control stages in the top level.
module mul_core
    import CDB_types::*;
#(
    parameter int STAGES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] en,
    input  logic [2:0]        in_funct3,
    input  logic [31:0]       in_a,
    input  logic [31:0]       in_b,
    input  logic [2:0]        sel_funct3,
    output logic [31:0]       result
);

    logic signed [32:0] a_ext, b_ext;
    logic signed [32:0] a_q, b_q;
    logic signed [65:0] prod;
    logic [31:0]        sel_val;
    logic [31:0]        res_q [1:STAGES-1];
    logic               unused_prod;

    // Operand extension: rs1 signed for MULH/MULHSU, rs2 signed for MULH only.
    always_comb begin
        a_ext = {((in_funct3 == MULH_OP) || (in_funct3 == MULHSU_OP)) && in_a[31], in_a};
        b_ext = {(in_funct3 == MULH_OP) && in_b[31], in_b};
    end

    // Stage 0 operand register.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (en[0]) begin
            a_q <= a_ext;
            b_q <= b_ext;
        end
    end

    assign prod        = 66'(a_q) * 66'(b_q);
    assign unused_prod = ^prod[65:64];

    // Pick low or high word according to the op sitting in stage 0.
    always_comb begin
        sel_val = '0;
        case (sel_funct3)
            MUL_OP:                       sel_val = prod[31:0];
            MULH_OP, MULHSU_OP, MULHU_OP: sel_val = prod[63:32];
            default:                      sel_val = '0;
        endcase
    end

    // Stage 1 captures the selected product word.
    always_ff @(posedge clk) begin
        if (rst)        res_q[1] <= '0;
        else if (en[1]) res_q[1] <= sel_val;
    end

    for (genvar g = 2; g < STAGES; g++) begin : g_pass
        // Later stages only carry the finished result forward.
        always_ff @(posedge clk) begin
            if (rst)        res_q[g] <= '0;
            else if (en[g]) res_q[g] <= res_q[g-1];
        end
    end

    assign result = res_q[STAGES-1];

endmodule

// File: rtl/mul_fu_pipe.sv
// Pipelined RV32M multiply unit placed behind a reservation station.
// Handshakes: an op transfers on issue when issue_valid && issue_ready at a
// rising clock edge; issue_ready never looks at issue_valid. A result
// transfers on the CDB when cdb_req && cdb_grant at a rising edge; cdb_req
// is simply the result stage's valid bit and cdb_* hold steady until granted.
module mul_fu_pipe
    import CDB_types::*;
#(
    parameter int STAGES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic [2:0]           issue_funct3,
    input  logic [31:0]          issue_rs1_v,
    input  logic [31:0]          issue_rs2_v,
    input  logic [PD_W-1:0]      issue_pd,
    input  logic [ROB_W-1:0]     issue_rob,
    input  logic [EBR_NUM-1:0]   issue_br_mask,
    input  logic                 early_flush,
    input  logic [EBR_IDX_W-1:0] flush_idx,
    input  logic                 resolve,
    input  logic [EBR_IDX_W-1:0] resolve_idx,
    output logic                 cdb_req,
    input  logic                 cdb_grant,
    output logic [PD_W-1:0]      cdb_pd,
    output logic [ROB_W-1:0]     cdb_rob,
    output logic [31:0]          cdb_value,
    output logic                 busy
);

    localparam int L = STAGES - 1;

    mul_stage_t        st  [STAGES];
    mul_stage_t        nxt [STAGES];
    mul_stage_t        incoming;
    logic [STAGES-1:0] adv;

    // Advance chain: result stage frees when empty or granted; each earlier
    // stage moves when the one ahead is empty or itself moving.
    always_comb begin
        adv    = '0;
        adv[L] = !st[L].valid || cdb_grant;
        for (int s = L - 1; s >= 0; s--) begin
            adv[s] = !st[s].valid || adv[s+1];
        end
    end

    assign issue_ready = adv[0] && !early_flush;

    // Op presented by the reservation station, valid only on a handshake.
    always_comb begin
        incoming.valid   = issue_valid && issue_ready;
        incoming.funct3  = issue_funct3;
        incoming.pd      = issue_pd;
        incoming.rob     = issue_rob;
        incoming.br_mask = issue_br_mask;
    end

    // Next stage contents: shift where advancing, hold otherwise, then apply
    // flush/resolve to whatever lands so moving ops are covered too.
    always_comb begin
        nxt[0] = adv[0] ? incoming : st[0];
        nxt[0] = apply_branch(nxt[0], early_flush, flush_idx, resolve, resolve_idx);
        for (int s = 1; s < STAGES; s++) begin
            nxt[s] = adv[s] ? st[s-1] : st[s];
            nxt[s] = apply_branch(nxt[s], early_flush, flush_idx, resolve, resolve_idx);
        end
    end

    // Control stage registers.
    always_ff @(posedge clk) begin
        for (int s = 0; s < STAGES; s++) begin
            if (rst) st[s] <= '0;
            else     st[s] <= nxt[s];
        end
    end

    // Busy whenever any stage holds a live op.
    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < STAGES; s++) busy = busy | st[s].valid;
    end

    assign cdb_req = st[L].valid;
    assign cdb_pd  = st[L].pd;
    assign cdb_rob = st[L].rob;

    mul_core #(
        .STAGES (STAGES)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .en         (adv),
        .in_funct3  (issue_funct3),
        .in_a       (issue_rs1_v),
        .in_b       (issue_rs2_v),
        .sel_funct3 (st[0].funct3),
        .result     (cdb_value)
    );

endmodule

// File: tb/tb_mul_fu_pipe.sv
// Directed + randomized bench for mul_fu_pipe with an in-order result
// scoreboard computed from 64-bit integer arithmetic.
module tb_mul_fu_pipe;
    import CDB_types::*;

    localparam int STAGES = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 issue_valid;
    logic                 issue_ready;
    logic [2:0]           issue_funct3;
    logic [31:0]          issue_rs1_v;
    logic [31:0]          issue_rs2_v;
    logic [PD_W-1:0]      issue_pd;
    logic [ROB_W-1:0]     issue_rob;
    logic [EBR_NUM-1:0]   issue_br_mask;
    logic                 early_flush;
    logic [EBR_IDX_W-1:0] flush_idx;
    logic                 resolve;
    logic [EBR_IDX_W-1:0] resolve_idx;
    logic                 cdb_req;
    logic                 cdb_grant;
    logic [PD_W-1:0]      cdb_pd;
    logic [ROB_W-1:0]     cdb_rob;
    logic [31:0]          cdb_value;
    logic                 busy;

    typedef struct packed {
        logic [PD_W-1:0]    pd;
        logic [ROB_W-1:0]   rob;
        logic [EBR_NUM-1:0] mask;
        logic [31:0]        val;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec   = 0;
    int   n_miss  = 0;
    int   n_bcast = 0;

    mul_fu_pipe #(.STAGES(STAGES)) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_funct3  (issue_funct3),
        .issue_rs1_v   (issue_rs1_v),
        .issue_rs2_v   (issue_rs2_v),
        .issue_pd      (issue_pd),
        .issue_rob     (issue_rob),
        .issue_br_mask (issue_br_mask),
        .early_flush   (early_flush),
        .flush_idx     (flush_idx),
        .resolve       (resolve),
        .resolve_idx   (resolve_idx),
        .cdb_req       (cdb_req),
        .cdb_grant     (cdb_grant),
        .cdb_pd        (cdb_pd),
        .cdb_rob       (cdb_rob),
        .cdb_value     (cdb_value),
        .busy          (busy)
    );

    // Clock.
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // RV32M result from 64-bit integer arithmetic.
    function automatic logic [31:0] ref_mul(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa, sb, su;
        logic [63:0] p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        su = longint'({32'd0, b});
        case (f)
            3'd0:    p = sa * sb;
            3'd1:    p = sa * sb;
            3'd2:    p = sa * su;
            3'd3:    p = {32'd0, a} * {32'd0, b};
            default: p = '0;
        endcase
        return (f == 3'd0) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard checks at the falling edge, model update, then
    // return 1ns after the rising edge so the caller can drive/check.
    task automatic step();
        logic exp_ready;
        exp_t op;
        exp_t keep[$];
        @(negedge clk);
        if (!rst) begin
            exp_ready = !early_flush && !(exp_q.size() == STAGES && !cdb_grant);
            check("issue_ready", 32'(issue_ready), 32'(exp_ready));
            check("busy", 32'(busy), 32'(exp_q.size() != 0));
            if (cdb_req) begin
                if (exp_q.size() == 0) begin
                    check("cdb_req_spurious", 32'(cdb_req), 32'd0);
                end else begin
                    check("cdb_pd", 32'(cdb_pd), 32'(exp_q[0].pd));
                    check("cdb_rob", 32'(cdb_rob), 32'(exp_q[0].rob));
                    check("cdb_value", cdb_value, exp_q[0].val);
                    if (cdb_grant) begin
                        void'(exp_q.pop_front());
                        n_bcast++;
                    end
                end
            end
            if (early_flush) begin
                foreach (exp_q[i]) if (!exp_q[i].mask[flush_idx]) keep.push_back(exp_q[i]);
                exp_q = keep;
            end else if (resolve) begin
                foreach (exp_q[i]) exp_q[i].mask[resolve_idx] = 1'b0;
            end
            if (issue_valid && exp_ready) begin
                op.pd   = issue_pd;
                op.rob  = issue_rob;
                op.mask = issue_br_mask;
                if (resolve && !early_flush) op.mask[resolve_idx] = 1'b0;
                op.val  = ref_mul(issue_funct3, issue_rs1_v, issue_rs2_v);
                exp_q.push_back(op);
            end
        end
        @(posedge clk);
        if (rst) exp_q.delete();
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        early_flush = 1'b0;
        resolve     = 1'b0;
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int pd, input int rob, input logic [3:0] mask);
        issue_valid   = 1'b1;
        issue_funct3  = f;
        issue_rs1_v   = a;
        issue_rs2_v   = b;
        issue_pd      = PD_W'(pd);
        issue_rob     = ROB_W'(rob);
        issue_br_mask = mask;
    endtask

    task automatic drain();
        int k;
        idle();
        cdb_grant = 1'b1;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 40) begin
            step();
            k++;
        end
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    logic [2:0]  tf [6];
    logic [31:0] ta [6];
    logic [31:0] tb [6];
    logic [31:0] te [6];

    initial begin
        int b0, k;

        tf[0] = MULH_OP;   ta[0] = 32'h8000_0000; tb[0] = 32'h8000_0000; te[0] = 32'h4000_0000;
        tf[1] = MULHU_OP;  ta[1] = 32'hFFFF_FFFF; tb[1] = 32'hFFFF_FFFF; te[1] = 32'hFFFF_FFFE;
        tf[2] = MULHSU_OP; ta[2] = 32'hFFFF_FFFF; tb[2] = 32'h0000_0002; te[2] = 32'hFFFF_FFFF;
        tf[3] = MUL_OP;    ta[3] = 32'hFFFF_FFFF; tb[3] = 32'hFFFF_FFFF; te[3] = 32'h0000_0001;
        tf[4] = MULH_OP;   ta[4] = 32'hFFFF_FFFF; tb[4] = 32'h0000_0001; te[4] = 32'hFFFF_FFFF;
        tf[5] = MULHSU_OP; ta[5] = 32'h8000_0000; tb[5] = 32'hFFFF_FFFF; te[5] = 32'h8000_0000;

        // Reset.
        rst = 1'b1;
        idle();
        issue(MUL_OP, 0, 0, 0, 0, 4'b0000);
        issue_valid = 1'b0;
        flush_idx   = '0;
        resolve_idx = '0;
        cdb_grant   = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cdb_req", 32'(cdb_req), 32'd0);
        check("rst_cdb_pd", 32'(cdb_pd), 32'd0);
        check("rst_cdb_rob", 32'(cdb_rob), 32'd0);
        check("rst_cdb_value", cdb_value, 32'd0);
        check("rst_issue_ready", 32'(issue_ready), 32'd1);

        // Latency: MUL 7*6 with grant held.
        cdb_grant = 1'b1;
        issue(MUL_OP, 7, 6, 5, 3, 4'b0000);
        step();
        idle();
        for (int i = 0; i < STAGES - 1; i++) begin
            check("lat_req_low", 32'(cdb_req), 32'd0);
            step();
        end
        check("lat_req_high", 32'(cdb_req), 32'd1);
        check("lat_value", cdb_value, 32'd42);
        check("lat_pd", 32'(cdb_pd), 32'd5);
        check("lat_rob", 32'(cdb_rob), 32'd3);
        step();
        check("lat_req_after", 32'(cdb_req), 32'd0);

        // Arithmetic corner cases.
        for (int i = 0; i < 6; i++) begin
            issue(tf[i], ta[i], tb[i], 40 + i, i, 4'b0000);
            step();
            idle();
            k = 0;
            while (!cdb_req && k < 10) begin
                cdb_grant = 1'b0;
                step();
                k++;
            end
            check("arith_req", 32'(cdb_req), 32'd1);
            check("arith_value", cdb_value, te[i]);
            cdb_grant = 1'b1;
            step();
        end
        drain();

        // Back-to-back with grant withheld.
        cdb_grant = 1'b0;
        issue(MUL_OP, 3, 5, 10, 1, 4'b0000);
        step();
        issue(MUL_OP, 4, 5, 11, 2, 4'b0000);
        step();
        issue(MULHU_OP, 32'hFFFF_FFFF, 32'h10, 12, 3, 4'b0000);
        step();
        issue(MUL_OP, 9, 9, 13, 4, 4'b0000);
        #1;
        check("stall_ready_low", 32'(issue_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_value", cdb_value, 32'd15);
            check("stall_pd", 32'(cdb_pd), 32'd10);
            check("stall_req", 32'(cdb_req), 32'd1);
        end
        cdb_grant = 1'b1;
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            check("stall_stream_req", 32'(cdb_req), 32'd1);
            step();
        end
        check("stall_stream_end", 32'(cdb_req), 32'd0);
        drain();

        // Early flush of slot 0 with three ops in flight.
        cdb_grant = 1'b0;
        issue(MUL_OP, 2, 3, 20, 5, 4'b0001);
        step();
        issue(MUL_OP, 2, 4, 21, 6, 4'b0010);
        step();
        issue(MUL_OP, 2, 5, 22, 7, 4'b0000);
        step();
        issue(MUL_OP, 2, 6, 23, 8, 4'b0000);
        early_flush = 1'b1;
        flush_idx   = 2'd0;
        #1;
        check("flush_ready_low", 32'(issue_ready), 32'd0);
        step();
        idle();
        check("flush_busy", 32'(busy), 32'd1);
        b0 = n_bcast;
        drain();
        check("flush_bcast", 32'(n_bcast - b0), 32'd2);

        // Resolve then flush on the same slot: op survives.
        cdb_grant = 1'b0;
        issue(MUL_OP, 11, 3, 30, 9, 4'b0100);
        step();
        idle();
        resolve     = 1'b1;
        resolve_idx = 2'd2;
        step();
        idle();
        early_flush = 1'b1;
        flush_idx   = 2'd2;
        step();
        idle();
        b0 = n_bcast;
        drain();
        check("resolve_survive", 32'(n_bcast - b0), 32'd1);

        // Resolve and flush together: flush wins, op killed.
        cdb_grant = 1'b0;
        issue(MUL_OP, 11, 4, 31, 10, 4'b0100);
        step();
        idle();
        resolve     = 1'b1;
        resolve_idx = 2'd2;
        early_flush = 1'b1;
        flush_idx   = 2'd2;
        step();
        idle();
        check("both_killed_busy", 32'(busy), 32'd0);
        b0 = n_bcast;
        drain();
        check("both_killed_bcast", 32'(n_bcast - b0), 32'd0);

        // Reset in the middle of a stall.
        cdb_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(MULH_OP, 32'(i + 100), 32'd7, 50 + i, 12 + i, 4'b0000);
            step();
        end
        idle();
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_req", 32'(cdb_req), 32'd0);
        check("mid_rst_ready", 32'(issue_ready), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            issue(3'($urandom_range(0, 3)), 32'd0, 32'd0, $urandom_range(0, 63),
                  $urandom_range(0, 31), 4'($urandom_range(0, 15)));
            issue_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       issue_rs1_v = 32'h8000_0000;
                1:       issue_rs1_v = 32'hFFFF_FFFF;
                default: issue_rs1_v = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       issue_rs2_v = 32'h8000_0000;
                1:       issue_rs2_v = 32'hFFFF_FFFF;
                default: issue_rs2_v = $urandom;
            endcase
            early_flush = ($urandom_range(0, 9) == 0);
            flush_idx   = EBR_IDX_W'($urandom_range(0, EBR_NUM - 1));
            resolve     = ($urandom_range(0, 3) == 0);
            resolve_idx = EBR_IDX_W'($urandom_range(0, EBR_NUM - 1));
            cdb_grant   = early_flush ? 1'b0 : ($urandom_range(0, 2) != 0);
            step();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
